// File: rtl/jtag_sba_ctrl.sv
// jtag_sba_ctrl
//   System-bus-access engine for the debug module. Owns the sbaddress0 and
//   sbdata0 registers, turns dmi accesses into single bus transactions on one
//   master port, and keeps the sticky sberror / sbbusyerror status.
//
//   Ports
//     clk, rst                   clock, asynchronous active-high reset
//     sbaddress_i/_we_i          dmi write of sbaddress0
//     sbdata_i/_we_i/_re_i       dmi write (starts a bus write) / read of sbdata0
//     sbreadonaddr_i             address write also starts a bus read
//     sbreadondata_i             sbdata0 read also starts a bus read
//     sbautoincrement_i          bump sbaddress0 by the access size on success
//     sbaccess_i                 access size, log2 of bytes
//     sberror_clr_i              write-1-to-clear mask for sberror
//     sbbusyerror_clr_i          clears sbbusyerror
//     sbaddress_o, sbdata_o      register contents (read data right-justified)
//     sbdata_valid_o             one-cycle pulse when a bus read updated sbdata_o
//     sbbusy_o                   a transaction is in flight
//     sberror_o, sbbusyerror_o   sticky status
//     master_*                   bus master port (req/gnt, rvalid response)

module jtag_sba_ctrl #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     sbaddress_i,
    input  logic                  sbaddress_we_i,
    input  logic [DATA_W-1:0]     sbdata_i,
    input  logic                  sbdata_we_i,
    input  logic                  sbdata_re_i,
    input  logic                  sbreadonaddr_i,
    input  logic                  sbreadondata_i,
    input  logic                  sbautoincrement_i,
    input  logic [2:0]            sbaccess_i,
    input  logic [2:0]            sberror_clr_i,
    input  logic                  sbbusyerror_clr_i,
    output logic [ADDR_W-1:0]     sbaddress_o,
    output logic [DATA_W-1:0]     sbdata_o,
    output logic                  sbdata_valid_o,
    output logic                  sbbusy_o,
    output logic [2:0]            sberror_o,
    output logic                  sbbusyerror_o,
    output logic                  master_req_o,
    input  logic                  master_gnt_i,
    input  logic                  master_rvalid_i,
    output logic                  master_we_o,
    output logic [DATA_W/8-1:0]   master_be_o,
    output logic [ADDR_W-1:0]     master_addr_o,
    output logic [DATA_W-1:0]     master_wdata_o,
    input  logic [DATA_W-1:0]     master_rdata_i,
    input  logic                  master_err_i
);

    localparam int NBE      = DATA_W / 8;
    localparam int SIZE_MAX = $clog2(NBE);
    localparam int OFF_W    = SIZE_MAX;
    localparam int CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [2:0] SIZE_MAX_L = 3'(SIZE_MAX);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t              state, state_d;
    logic [ADDR_W-1:0]   sbaddress_q, sbaddress_d;
    logic [DATA_W-1:0]   sbdata_q, sbdata_d;
    logic                sbdata_valid_q, sbdata_valid_d;
    logic [2:0]          sberror_q, sberror_d;
    logic                sbbusyerror_q, sbbusyerror_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [NBE-1:0]      be_q, be_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [OFF_W-1:0]    off_q, off_d;
    logic [2:0]          acc_q, acc_d;

    logic [ADDR_W-1:0]   eff_addr;
    logic [DATA_W-1:0]   eff_data;
    logic [OFF_W-1:0]    eff_off;
    logic                trig_wr, trig_rd, dmi_access, misaligned, timed_out;
    logic                set_err;
    logic [2:0]          err_val;
    logic                busy_set;

    // Byte enables covering 2^acc bytes starting at byte offset off.
    function automatic logic [NBE-1:0] lane_be(input logic [OFF_W-1:0] off, input logic [2:0] acc);
        logic [NBE-1:0] be;
        be = '0;
        for (int b = 0; b < NBE; b++) begin
            be[b] = (b >= int'(off)) && (b < int'(off) + (1 << acc));
        end
        return be;
    endfunction

    // Right-justify the addressed lanes of a read beat and zero everything above.
    function automatic logic [DATA_W-1:0] lane_read(input logic [DATA_W-1:0] rd,
                                                    input logic [OFF_W-1:0] off,
                                                    input logic [2:0] acc);
        logic [DATA_W-1:0] sh;
        sh = rd >> {off, 3'b000};
        for (int b = 0; b < NBE; b++) begin
            if (b >= (1 << acc)) begin
                sh[b*8 +: 8] = 8'h00;
            end
        end
        return sh;
    endfunction

    // Registers written in the same cycle feed the access they trigger.
    assign eff_addr   = sbaddress_we_i ? sbaddress_i : sbaddress_q;
    assign eff_data   = sbdata_we_i ? sbdata_i : sbdata_q;
    assign eff_off    = eff_addr[OFF_W-1:0];
    assign trig_wr    = sbdata_we_i;
    assign trig_rd    = (sbaddress_we_i & sbreadonaddr_i) | (sbdata_re_i & sbreadondata_i);
    assign dmi_access = sbaddress_we_i | sbdata_we_i | sbdata_re_i;
    assign misaligned = |(eff_off & OFF_W'((1 << sbaccess_i) - 1));
    assign timed_out  = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d        = state;
        sbaddress_d    = sbaddress_q;
        sbdata_d       = sbdata_q;
        sbdata_valid_d = 1'b0;
        we_d           = we_q;
        be_d           = be_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        off_d          = off_q;
        acc_d          = acc_q;
        set_err        = 1'b0;
        err_val        = 3'd0;
        busy_set       = 1'b0;

        case (state)
            S_IDLE: begin
                if (sbaddress_we_i) sbaddress_d = sbaddress_i;
                if (sbdata_we_i)    sbdata_d    = sbdata_i;
                if ((trig_wr || trig_rd) && (sberror_q == 3'd0) && !sbbusyerror_q) begin
                    if (sbaccess_i > SIZE_MAX_L) begin
                        set_err = 1'b1;
                        err_val = 3'd4;
                    end else if (misaligned) begin
                        set_err = 1'b1;
                        err_val = 3'd3;
                    end else begin
                        state_d = S_REQ;
                        we_d    = trig_wr;
                        addr_d  = {eff_addr[ADDR_W-1:SIZE_MAX], {SIZE_MAX{1'b0}}};
                        be_d    = lane_be(eff_off, sbaccess_i);
                        wdata_d = eff_data << {eff_off, 3'b000};
                        off_d   = eff_off;
                        acc_d   = sbaccess_i;
                    end
                end
            end
            S_REQ: begin
                busy_set = dmi_access;
                if (timed_out) begin
                    state_d = S_IDLE;
                    set_err = 1'b1;
                    err_val = 3'd1;
                end else if (master_gnt_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                busy_set = dmi_access;
                // A response arriving on the last allowed cycle still completes normally.
                if (master_rvalid_i) begin
                    state_d = S_IDLE;
                    if (master_err_i) begin
                        set_err = 1'b1;
                        err_val = 3'd2;
                    end else begin
                        if (!we_q) begin
                            sbdata_d       = lane_read(master_rdata_i, off_q, acc_q);
                            sbdata_valid_d = 1'b1;
                        end
                        if (sbautoincrement_i) begin
                            sbaddress_d = sbaddress_q + (ADDR_W'(1) << acc_q);
                        end
                    end
                end else if (timed_out) begin
                    state_d = S_IDLE;
                    set_err = 1'b1;
                    err_val = 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        cnt_d = ((state == S_IDLE) || (state_d == S_IDLE)) ? '0 : cnt_q + CNT_W'(1);

        // A same-cycle set wins over the clear.
        sberror_d     = set_err ? err_val : (sberror_q & ~sberror_clr_i);
        sbbusyerror_d = busy_set | (sbbusyerror_q & ~sbbusyerror_clr_i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            sbaddress_q    <= '0;
            sbdata_q       <= '0;
            sbdata_valid_q <= 1'b0;
            sberror_q      <= 3'd0;
            sbbusyerror_q  <= 1'b0;
            cnt_q          <= '0;
            we_q           <= 1'b0;
            be_q           <= '0;
            addr_q         <= '0;
            wdata_q        <= '0;
            off_q          <= '0;
            acc_q          <= 3'd0;
        end else begin
            state          <= state_d;
            sbaddress_q    <= sbaddress_d;
            sbdata_q       <= sbdata_d;
            sbdata_valid_q <= sbdata_valid_d;
            sberror_q      <= sberror_d;
            sbbusyerror_q  <= sbbusyerror_d;
            cnt_q          <= cnt_d;
            we_q           <= we_d;
            be_q           <= be_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            off_q          <= off_d;
            acc_q          <= acc_d;
        end
    end

    // Request decodes straight from the state register so reset drops it at once.
    assign master_req_o   = (state == S_REQ);
    assign sbbusy_o       = (state != S_IDLE);
    assign master_we_o    = we_q;
    assign master_be_o    = be_q;
    assign master_addr_o  = addr_q;
    assign master_wdata_o = wdata_q;
    assign sbaddress_o    = sbaddress_q;
    assign sbdata_o       = sbdata_q;
    assign sbdata_valid_o = sbdata_valid_q;
    assign sberror_o      = sberror_q;
    assign sbbusyerror_o  = sbbusyerror_q;

endmodule

// File: tb/tb_jtag_sba_ctrl.sv
// Bench for jtag_sba_ctrl: a 64-bit instance driven by randomized dmi
// operations against a register-level reference model, plus a 32-bit
// instance for the narrow-bus lane and size checks.

module tb_jtag_sba_ctrl;

    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 64-bit instance
    logic [31:0] sbaddress_i;
    logic        sbaddress_we, sbdata_we, sbdata_re, roa, rod, ai, bclr;
    logic [63:0] sbdata_i;
    logic [2:0]  acc, eclr;
    logic [31:0] sbaddress_o;
    logic [63:0] sbdata_o;
    logic        valid, busy, sbbusyerror, req, gnt, rvalid, we, merr;
    logic [2:0]  sberror;
    logic [7:0]  be;
    logic [31:0] maddr;
    logic [63:0] wdata, rdata;

    jtag_sba_ctrl #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .sbaddress_i(sbaddress_i), .sbaddress_we_i(sbaddress_we),
        .sbdata_i(sbdata_i), .sbdata_we_i(sbdata_we), .sbdata_re_i(sbdata_re),
        .sbreadonaddr_i(roa), .sbreadondata_i(rod), .sbautoincrement_i(ai),
        .sbaccess_i(acc), .sberror_clr_i(eclr), .sbbusyerror_clr_i(bclr),
        .sbaddress_o(sbaddress_o), .sbdata_o(sbdata_o), .sbdata_valid_o(valid),
        .sbbusy_o(busy), .sberror_o(sberror), .sbbusyerror_o(sbbusyerror),
        .master_req_o(req), .master_gnt_i(gnt), .master_rvalid_i(rvalid),
        .master_we_o(we), .master_be_o(be), .master_addr_o(maddr),
        .master_wdata_o(wdata), .master_rdata_i(rdata), .master_err_i(merr)
    );

    // 32-bit instance
    logic [31:0] a32_addr, a32_data, a32_addr_o, a32_data_o, a32_maddr, a32_wdata;
    logic        a32_addr_we, a32_data_we, a32_valid, a32_busy, a32_berr;
    logic        a32_req, a32_gnt, a32_rvalid, a32_we;
    logic [2:0]  a32_acc, a32_err;
    logic [3:0]  a32_be;

    jtag_sba_ctrl #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TO)) dut32 (
        .clk(clk), .rst(rst),
        .sbaddress_i(a32_addr), .sbaddress_we_i(a32_addr_we),
        .sbdata_i(a32_data), .sbdata_we_i(a32_data_we), .sbdata_re_i(1'b0),
        .sbreadonaddr_i(1'b0), .sbreadondata_i(1'b0), .sbautoincrement_i(1'b0),
        .sbaccess_i(a32_acc), .sberror_clr_i(3'b000), .sbbusyerror_clr_i(1'b0),
        .sbaddress_o(a32_addr_o), .sbdata_o(a32_data_o), .sbdata_valid_o(a32_valid),
        .sbbusy_o(a32_busy), .sberror_o(a32_err), .sbbusyerror_o(a32_berr),
        .master_req_o(a32_req), .master_gnt_i(a32_gnt), .master_rvalid_i(a32_rvalid),
        .master_we_o(a32_we), .master_be_o(a32_be), .master_addr_o(a32_maddr),
        .master_wdata_o(a32_wdata), .master_rdata_i(32'h0), .master_err_i(1'b0)
    );

    typedef struct {
        logic        we;
        logic [7:0]  be;
        logic [31:0] addr;
        logic [63:0] wdata;
    } req_t;

    req_t        exp_q[$];
    logic [63:0] dat_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] m_addr;
    logic [63:0] m_data;
    logic [2:0]  m_err;
    logic        m_berr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] m_be(input logic [2:0] off, input logic [2:0] ac);
        logic [15:0] b;
        b = ((16'd1 << (1 << ac)) - 16'd1) << off;
        return b[7:0];
    endfunction

    function automatic logic [63:0] m_wdata(input logic [63:0] d, input logic [2:0] off);
        logic [127:0] t;
        t = {64'd0, d} << (8 * off);
        return t[63:0];
    endfunction

    function automatic logic [63:0] m_extract(input logic [63:0] rd, input logic [2:0] off, input logic [2:0] ac);
        logic [127:0] sh, mask;
        sh   = {64'd0, rd} >> (8 * off);
        mask = (128'd1 << (8 << ac)) - 128'd1;
        sh   = sh & mask;
        return sh[63:0];
    endfunction

    // Monitor: bus requests and read-data pulses against the scoreboard
    logic prev_req = 1'b0;
    always @(negedge clk) begin
        if (req) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_req: got req=1 addr=%h expected no request", maddr);
            end else begin
                check("req_we", {63'd0, we}, {63'd0, exp_q[0].we});
                check("req_be", {56'd0, be}, {56'd0, exp_q[0].be});
                check("req_addr", {32'd0, maddr}, {32'd0, exp_q[0].addr});
                if (exp_q[0].we) check("req_wdata", wdata, exp_q[0].wdata);
            end
        end
        if (prev_req && !req && exp_q.size() > 0) void'(exp_q.pop_front());
        if (valid) begin
            if (dat_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid: got sbdata=%h expected no pulse", sbdata_o);
            end else begin
                check("rd_data", sbdata_o, dat_q.pop_front());
            end
        end
        prev_req <= req;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_sberror"}, {61'd0, sberror}, {61'd0, m_err});
        check({tag, "_busyerr"}, {63'd0, sbbusyerror}, {63'd0, m_berr});
        check({tag, "_sbaddress"}, {32'd0, sbaddress_o}, {32'd0, m_addr});
        check({tag, "_sbdata"}, sbdata_o, m_data);
        check({tag, "_sbbusy"}, {63'd0, busy}, 64'd0);
    endtask

    // kind: 0 = write via sbdata, 1 = read on address write, 2 = read on sbdata read
    task automatic run_op(input int kind, input logic [31:0] a, input logic [63:0] d,
                          input logic [2:0] ac, input logic inc, input int gd, input int rd,
                          input logic e, input logic [63:0] rdv, input logic binj);
        logic       go;
        logic [2:0] off;
        req_t       r;
        int         w;
        acc = ac;
        ai  = inc;
        if (kind != 1) begin
            sbaddress_i = a; sbaddress_we = 1'b1;
            step();
            sbaddress_we = 1'b0;
            m_addr = a;
        end
        case (kind)
            0: begin sbdata_i = d; sbdata_we = 1'b1; m_data = d; end
            1: begin sbaddress_i = a; sbaddress_we = 1'b1; roa = 1'b1; m_addr = a; end
            default: begin sbdata_re = 1'b1; rod = 1'b1; end
        endcase
        go = 1'b0;
        if (m_err == 3'd0 && !m_berr) begin
            if (ac > 3'd3) m_err = 3'd4;
            else if ((m_addr & ((32'd1 << ac) - 32'd1)) != 32'd0) m_err = 3'd3;
            else go = 1'b1;
        end
        off = m_addr[2:0];
        if (go) begin
            r.we = (kind == 0); r.be = m_be(off, ac);
            r.addr = m_addr & ~32'd7; r.wdata = m_wdata(m_data, off);
            exp_q.push_back(r);
        end
        step();
        sbdata_we = 1'b0; sbaddress_we = 1'b0; sbdata_re = 1'b0; roa = 1'b0; rod = 1'b0;
        if (go) begin
            w = 0;
            while (!req && w < 8) begin step(); w++; end
            check("req_seen", {63'd0, req}, 64'd1);
            repeat (gd) step();
            gnt = 1'b1;
            step();
            gnt = 1'b0;
            for (int i = 0; i <= rd; i++) begin
                if (i == rd) begin rvalid = 1'b1; rdata = rdv; merr = e; end
                if (binj && i == 0) begin sbdata_i = {$urandom, $urandom}; sbdata_we = 1'b1; end
                step();
                rvalid = 1'b0; merr = 1'b0; sbdata_we = 1'b0;
            end
            if (binj) m_berr = 1'b1;
            if (e) m_err = 3'd2;
            else begin
                if (kind != 0) begin
                    m_data = m_extract(rdv, off, ac);
                    dat_q.push_back(m_data);
                end
                if (inc) m_addr = m_addr + (32'd1 << ac);
            end
        end
        @(negedge clk);
        check_regs("op");
    endtask

    task automatic clear_err(input logic [2:0] m, input logic b);
        eclr = m; bclr = b;
        step();
        eclr = 3'd0; bclr = 1'b0;
        m_err = m_err & ~m;
        if (b) m_berr = 1'b0;
        @(negedge clk);
        check("clr_sberror", {61'd0, sberror}, {61'd0, m_err});
        check("clr_busyerr", {63'd0, sbbusyerror}, {63'd0, m_berr});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [2:0]  ac;
        req_t        r;
        int          cnt;

        rst = 1'b1;
        sbaddress_i = '0; sbaddress_we = 0; sbdata_i = '0; sbdata_we = 0; sbdata_re = 0;
        roa = 0; rod = 0; ai = 0; acc = 0; eclr = 0; bclr = 0;
        gnt = 0; rvalid = 0; rdata = '0; merr = 0;
        a32_addr = '0; a32_data = '0; a32_addr_we = 0; a32_data_we = 0; a32_acc = 0;
        a32_gnt = 0; a32_rvalid = 0;
        m_addr = '0; m_data = '0; m_err = '0; m_berr = 0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_regs("reset");
        check("reset_req", {63'd0, req}, 64'd0);
        check("reset_valid", {63'd0, valid}, 64'd0);

        // 32-bit halfword write on the upper lanes
        step();
        a32_addr = 32'h1000_0002; a32_addr_we = 1'b1; a32_acc = 3'd1;
        step();
        a32_addr_we = 1'b0; a32_data = 32'h0000_ABCD; a32_data_we = 1'b1;
        step();
        a32_data_we = 1'b0;
        @(negedge clk);
        check("w32_req", {63'd0, a32_req}, 64'd1);
        check("w32_we", {63'd0, a32_we}, 64'd1);
        check("w32_be", {60'd0, a32_be}, 64'hC);
        check("w32_addr", {32'd0, a32_maddr}, 64'h1000_0000);
        check("w32_wdata", {32'd0, a32_wdata}, 64'hABCD_0000);
        step();
        a32_gnt = 1'b1;
        step();
        a32_gnt = 1'b0; a32_rvalid = 1'b1;
        step();
        a32_rvalid = 1'b0;
        @(negedge clk);
        check("w32_done_busy", {63'd0, a32_busy}, 64'd0);
        check("w32_done_err", {61'd0, a32_err}, 64'd0);
        // doubleword is too wide for a 32-bit bus
        step();
        a32_addr = 32'h1000_0000; a32_addr_we = 1'b1; a32_acc = 3'd3;
        step();
        a32_addr_we = 1'b0; a32_data_we = 1'b1;
        step();
        a32_data_we = 1'b0;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (a32_req) cnt++;
        end
        check("w32_size_noreq", cnt, 0);
        check("w32_size_err", {61'd0, a32_err}, 64'd4);

        // 64-bit read on address write with autoincrement
        run_op(1, 32'h8000_0004, 64'd0, 3'd2, 1'b1, 1, 1, 1'b0, 64'h1122_3344_5566_7788, 1'b0);
        check("r64_data", sbdata_o, 64'h0000_0000_1122_3344);
        check("r64_addr", {32'd0, sbaddress_o}, 64'h8000_0008);

        // autoincrement wraps at the top of the address space
        run_op(0, 32'hFFFF_FFFC, 64'h1234_5678, 3'd2, 1'b1, 0, 0, 1'b0, 64'd0, 1'b0);
        check("wrap_addr", {32'd0, sbaddress_o}, 64'd0);

        // misaligned word and oversized access
        run_op(0, 32'h2000_0001, 64'h77, 3'd2, 1'b0, 0, 0, 1'b0, 64'd0, 1'b0);
        check("misalign_err", {61'd0, sberror}, 64'd3);
        clear_err(3'b111, 1'b0);
        run_op(2, 32'h2000_0000, 64'd0, 3'd4, 1'b0, 0, 0, 1'b0, 64'd0, 1'b0);
        check("size_err", {61'd0, sberror}, 64'd4);
        clear_err(3'b111, 1'b0);

        // busy error during WAIT plus a bus error response
        run_op(0, 32'h3000_0010, 64'h0000_CAFE, 3'd3, 1'b1, 0, 2, 1'b1, 64'd0, 1'b1);
        check("busy_flag", {63'd0, sbbusyerror}, 64'd1);
        check("buserr_code", {61'd0, sberror}, 64'd2);
        check("buserr_noinc", {32'd0, sbaddress_o}, 64'h3000_0010);
        check("busy_data_kept", sbdata_o, 64'h0000_CAFE);
        clear_err(3'b111, 1'b1);

        // grant withheld: timeout after TO cycles of request
        sbaddress_i = 32'h0000_0100; sbaddress_we = 1'b1; acc = 3'd2;
        step();
        sbaddress_we = 1'b0; m_addr = 32'h0000_0100;
        sbdata_i = 64'h55; sbdata_we = 1'b1; m_data = 64'h55;
        r.we = 1'b1; r.be = 8'h0F; r.addr = 32'h0000_0100; r.wdata = 64'h55;
        exp_q.push_back(r);
        step();
        sbdata_we = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (req) cnt++;
            else break;
        end
        check("timeout_len", cnt, TO);
        m_err = 3'd1;
        check("timeout_err", {61'd0, sberror}, 64'd1);
        run_op(0, 32'h0000_0200, 64'h99, 3'd2, 1'b0, 0, 0, 1'b0, 64'd0, 1'b0);
        run_op(1, 32'h0000_0208, 64'd0, 3'd3, 1'b0, 0, 0, 1'b0, 64'd0, 1'b0);
        clear_err(3'b111, 1'b0);

        // randomized traffic
        for (int it = 0; it < 200; it++) begin
            if ((m_err != 3'd0 || m_berr) && ($urandom_range(0, 2) != 0))
                clear_err(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            ac = 3'($urandom_range(0, 4));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << ac) - 32'd1);
            run_op(int'($urandom_range(0, 2)), a, {$urandom, $urandom}, ac,
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                   ($urandom_range(0, 7) == 0), {$urandom, $urandom}, ($urandom_range(0, 9) == 0));
        end
        clear_err(3'b111, 1'b1);

        // reset in the middle of a request
        acc = 3'd3; ai = 1'b0;
        sbaddress_i = 32'h0000_4000; sbaddress_we = 1'b1;
        step();
        sbaddress_we = 1'b0; m_addr = 32'h0000_4000;
        sbdata_i = 64'hDEAD_BEEF; sbdata_we = 1'b1; m_data = 64'hDEAD_BEEF;
        r.we = 1'b1; r.be = 8'hFF; r.addr = 32'h0000_4000; r.wdata = 64'hDEAD_BEEF;
        exp_q.push_back(r);
        step();
        sbdata_we = 1'b0;
        repeat (3) step();
        check("pre_rst_req", {63'd0, req}, 64'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_req_async", {63'd0, req}, 64'd0);
        check("rst_busy_async", {63'd0, busy}, 64'd0);
        step();
        step();
        rst = 1'b0;
        m_addr = '0; m_data = '0; m_err = '0; m_berr = 1'b0;
        @(negedge clk);
        check_regs("post_rst");

        repeat (3) step();
        check("exp_q_empty", exp_q.size(), 0);
        check("dat_q_empty", dat_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
